regfile_mp_sb: RTL

//  Parametrised multi-port integer register file for the pipelined core, with a
//  per-register pending scoreboard. Replaces the single-write, two-read, negedge file.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_sb.sv | 62 ++++++
 rtl/regfile_mp_sb.sv | 109 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, data type and address decode helper for the multi-port register file.
// Build with `define REGFILE_BYPASS_EN to enable same-cycle write-to-read forwarding.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int NUM_RD_DEF   = 2;
  localparam int NUM_WR_DEF   = 1;
  localparam int DBG_REG_DEF  = 10;

  // Upper bound on register count; addresses are widened to 8 bits before decoding.
  localparam int MAX_REGS = 256;
  localparam int REG_ZERO = 0;

  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  function automatic logic [MAX_REGS-1:0] onehot_dec(input logic [7:0] addr);
    logic [MAX_REGS-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_sb.sv
// Pending-bit scoreboard: flush/issue/writeback next-state priority and per-port busy lookup.
// Busy is masked by the top-level bypass hits, which are zero unless REGFILE_BYPASS_EN is set.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rs_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_rd,
  input  logic                     flush,
  input  logic [NUM_RD-1:0]        byp_hit,
  output logic [NUM_RD-1:0]        rs_busy
);

  typedef logic [NUM_REGS-1:0] oh_t;

  oh_t pend_q;
  oh_t pend_d;
  oh_t wr_hit;
  oh_t iss_hit;

  // A fresh issue wins over a same-cycle writeback; flush wins over both.
  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        wr_hit = wr_hit | oh_t'(onehot_dec(8'(wr_addr[j*ADDR_W +: ADDR_W])));
      end
    end
    iss_hit = iss_en ? oh_t'(onehot_dec(8'(iss_rd))) : '0;
    if (flush) begin
      pend_d = '0;
    end else begin
      pend_d = (pend_q & ~wr_hit) | iss_hit;
    end
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    rs_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rs_busy[k] = (|(pend_q & oh_t'(onehot_dec(8'(rs_addr[k*ADDR_W +: ADDR_W]))))) & ~byp_hit[k];
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with pending scoreboard: storage, write arbitration, read muxes.
// `define REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int   DATA_W   = DATA_W_DEF,
  parameter int   NUM_REGS = NUM_REGS_DEF,
  parameter int   NUM_RD   = NUM_RD_DEF,
  parameter int   NUM_WR   = NUM_WR_DEF,
  parameter int   DBG_REG  = DBG_REG_DEF,
  localparam int  ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rs_addr,
  output logic [NUM_RD*DATA_W-1:0] rs_data,
  output logic [NUM_RD-1:0]        rs_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_rd,
  input  logic                     flush,
  output logic [DATA_W-1:0]        dbg_data
);

  typedef logic [NUM_REGS-1:0] oh_t;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  oh_t               wr_oh  [NUM_WR];
  oh_t               rd_oh  [NUM_RD];
  logic [NUM_RD-1:0] byp_hit;

  // Out-of-range addresses decode to all-zero, so they neither write, read nor bypass.
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wr_oh[j] = wr_en[j] ? oh_t'(onehot_dec(8'(wr_addr[j*ADDR_W +: ADDR_W]))) : '0;
      wr_oh[j][REG_ZERO] = 1'b0;
    end
    for (int k = 0; k < NUM_RD; k++) begin
      rd_oh[k] = oh_t'(onehot_dec(8'(rs_addr[k*ADDR_W +: ADDR_W])));
      rd_oh[k][REG_ZERO] = 1'b0;
    end
  end

  // Later ports overwrite earlier ones, so the highest index wins an address conflict.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_oh[j][r]) begin
          regs_d[r] = wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rs_data = '0;
    byp_hit = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (rd_oh[k][r]) begin
          rs_data[k*DATA_W +: DATA_W] = regs_q[r];
        end
      end
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (|(rd_oh[k] & wr_oh[j])) begin
          rs_data[k*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
          byp_hit[k]                  = 1'b1;
        end
      end
`endif
    end
  end

  assign dbg_data = regs_q[DBG_REG];

  regfile_sb #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .rs_addr (rs_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd),
    .flush   (flush),
    .byp_hit (byp_hit),
    .rs_busy (rs_busy)
  );

endmodule
